ofmap_streamer: RTL
===================

# ofmap_streamer

Drains the GEMM output-feature-map BRAM (mem2, 14 lanes × 8 bit per word) after the GEMM core raises `finish_o`. It reads mem2 sequentially through its second port and presents each word on a valid/ready stream toward the next layer or the host DMA. A 2-entry output buffer absorbs the 1-cycle BRAM read latency, so full throughput is kept under arbitrary backpressure.

## Interface
- `DATA_WIDTH`, 8, lane width
- `PE_SIZE`, 14, lanes per word
- `MEM2_DATA_WIDTH`, 112, word width (= `DATA_WIDTH*PE_SIZE`)
- `MEM2_DEPTH`, 896, words to drain
- `MEM2_ADDR_WIDTH`, 10, BRAM address width
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start_i` in 1: begin drain; sampled only in IDLE
- `mem2_ce1` out 1: BRAM port-1 chip enable
- `mem2_we1` out 1: BRAM port-1 write enable, constant 0
- `mem2_addr1` out `MEM2_ADDR_WIDTH`: read address
- `mem2_q1_i` in `MEM2_DATA_WIDTH`: read data, valid 1 cycle after `ce`
- `m_valid_o` out 1: output word valid
- `m_ready_i` in 1: downstream accept
- `m_data_o` out `MEM2_DATA_WIDTH`: output word; lane 0 in `[111:104]`
- `m_last_o` out 1: marks word `MEM2_DEPTH-1`
- `busy_o` out 1: high outside IDLE
- `done_o` out 1: 1-cycle pulse at completion

## Operation
- States: IDLE → STREAM → DONE → IDLE.
- IDLE: `start_i`=1 → STREAM, with read address and counters cleared. `start_i` is ignored in every other state.
- STREAM, read issue:
  - A read issues (`mem2_ce1`=1, `mem2_addr1`=rd_addr, then rd_addr+1) when rd_addr < `MEM2_DEPTH` and (occupancy + in-flight − pop_this_cycle) < 2.
  - At most one read is in flight.
- STREAM, capture and output:
  - Captured `mem2_q1_i` is pushed into the 2-entry FIFO.
  - A pop happens on `m_valid_o && m_ready_i`.
  - `m_last_o` = valid && head word index == `MEM2_DEPTH-1`.
- STREAM → DONE on the handshake of the last word.
- DONE: `done_o`=1 for exactly one cycle, then IDLE.
- Stream rules:
  - Once `m_valid_o` is high, `m_valid_o`, `m_data_o` and `m_last_o` hold until the handshake.
  - Words are delivered in address order with no loss or duplication.
- Address counter width is `MEM2_ADDR_WIDTH+1` internally, so reaching `MEM2_DEPTH` terminates without wrapping. `mem2_addr1` is 0 whenever `mem2_ce1`=0.

## Timing
- Reset values: `mem2_ce1`=0, `mem2_we1`=0, `mem2_addr1`=0, `m_valid_o`=0, `m_data_o`=0, `m_last_o`=0, `busy_o`=0, `done_o`=0. FIFO is empty and the state is IDLE.
- `start_i` sampled at edge E: `mem2_ce1`=1 with addr 0 in cycle E+1, and `m_valid_o`=1 from cycle E+2. First-word latency is 2 cycles.
- With `m_ready_i` held high: one word per cycle, last handshake at cycle E+1+`MEM2_DEPTH`, `done_o` in the following cycle.
- When `m_ready_i` drops while a read is in flight, the word is captured into the second FIFO slot and no read issues until a pop.
- Simultaneous push and pop with occupancy 1 keeps occupancy at 1 and the read may issue in the same cycle.
- `rst` mid-stream: next cycle equals the reset state. The in-flight read is discarded, with no `done_o`.

## Configuration
- `OFMAP_RELU_EN` defined: each lane of `m_data_o` is treated as signed 8-bit and negative lanes are forced to 0 on the output path. This is combinational after the FIFO and adds no latency.
- Not defined: lanes pass through unmodified.

## Structure
- Package `ofmap_pkg` holds:
  - the state enum (`S_IDLE`, `S_STREAM`, `S_DONE`)
  - `PE_SIZE` and the lane/word width constants
  - a lane-index-to-bit-slice helper function
- Sub-module `fifo2_sync` is a 2-entry synchronous FIFO with push, pop, full, empty and count. It has no combinational path from push data to output.
- Top level contains the FSM, the address counter, the in-flight flag, the output word index and the ReLU stage.

## Test plan
- Preload mem2 with word i = lane bytes all equal to (i mod 256), `m_ready_i`=1, pulse `start_i` → 896 words in order, `m_valid_o` at E+2, `m_last_o` only on word 895, one `done_o` pulse.
- Random `m_ready_i` (50%) → same 896-word sequence, data held stable while stalled, `mem2_ce1` never asserted with FIFO full and a read in flight.
- `m_ready_i`=0 for 20 cycles right after start → exactly 2 reads issued (addr 0, 1); the stream resumes at word 0 on release.
- Assert `rst` after word 300 is accepted, then restart → all outputs return to reset values within 1 cycle; the second run begins at addr 0.
- With `OFMAP_RELU_EN`, word lanes {0x80, 0xFF, 0x01, 0x7F, …} → output {0x00, 0x00, 0x01, 0x7F, …}. Without the macro the output is unchanged.
- `start_i` held high during STREAM and DONE → no restart and exactly one `done_o`. It is then accepted again in IDLE.

Source files
------------

// File: rtl/ofmap_streamer_pkg.sv
// rtl/ofmap_streamer_pkg.sv - shared constants, state type and lane slicing helper for ofmap_streamer
package ofmap_pkg;

  localparam int DATA_WIDTH      = 8;
  localparam int PE_SIZE         = 14;
  localparam int MEM2_DATA_WIDTH = DATA_WIDTH * PE_SIZE;
  localparam int MEM2_DEPTH      = 896;
  localparam int MEM2_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  // Lane 0 sits in the most significant byte of a word.
  function automatic int lane_lsb(input int lane);
    return (PE_SIZE - 1 - lane) * DATA_WIDTH;
  endfunction

endpackage

// File: rtl/ofmap_streamer_if.sv
// rtl/ofmap_streamer_if.sv - valid/ready output word stream of ofmap_streamer
interface ofmap_streamer_if
  import ofmap_pkg::*;
();

  logic                       m_valid_o;
  logic                       m_ready_i;
  logic [MEM2_DATA_WIDTH-1:0] m_data_o;
  logic                       m_last_o;

  modport master (
    output m_valid_o,
    output m_data_o,
    output m_last_o,
    input  m_ready_i
  );

  modport slave (
    input  m_valid_o,
    input  m_data_o,
    input  m_last_o,
    output m_ready_i
  );

endinterface

// File: rtl/ofmap_streamer_fifo2.sv
// rtl/ofmap_streamer_fifo2.sv - 2-entry synchronous FIFO; head comes only from storage registers
module fifo2_sync #(
  parameter int WIDTH = 112
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot [2];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot[0] <= '0;
      slot[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (push) begin
        slot[wr_ptr] <= push_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_comb begin
    head  = slot[rd_ptr];
    full  = (count == 2'd2);
    empty = (count == 2'd0);
  end

endmodule

// File: rtl/ofmap_streamer.sv
// rtl/ofmap_streamer.sv - drains mem2 in address order onto a valid/ready stream
// Optional macro OFMAP_RELU_EN: clamps negative signed lanes to zero on the output path.
module ofmap_streamer
  import ofmap_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  output logic                       mem2_ce1,
  output logic                       mem2_we1,
  output logic [MEM2_ADDR_WIDTH-1:0] mem2_addr1,
  input  logic [MEM2_DATA_WIDTH-1:0] mem2_q1_i,
  ofmap_streamer_if.master           m,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam logic [MEM2_ADDR_WIDTH:0] DEPTH_C = (MEM2_ADDR_WIDTH+1)'(MEM2_DEPTH);
  localparam logic [MEM2_ADDR_WIDTH:0] LAST_C  = (MEM2_ADDR_WIDTH+1)'(MEM2_DEPTH - 1);

  state_t                     state;
  state_t                     state_nxt;
  logic [MEM2_ADDR_WIDTH:0]   rd_addr;
  logic [MEM2_ADDR_WIDTH:0]   out_idx;
  logic                       inflight;
  logic                       in_stream;
  logic                       out_valid;
  logic                       handshake;
  logic                       rd_issue;
  logic [2:0]                 occ_after;
  logic                       fifo_push;
  logic                       fifo_pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [1:0]                 fifo_count;
  logic [MEM2_DATA_WIDTH-1:0] fifo_head;
  logic [MEM2_DATA_WIDTH-1:0] raw_word;
  logic [MEM2_DATA_WIDTH-1:0] out_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_i) state_nxt = S_STREAM;
      S_STREAM: if (handshake && out_idx == LAST_C) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state != S_IDLE);
    done_o = (state == S_DONE);
  end

  // An empty FIFO forwards the returning BRAM word directly to keep the
  // first-word latency at two cycles; a stalled forwarded word is pushed.
  always_comb begin
    in_stream = (state == S_STREAM);
    out_valid = in_stream && (!fifo_empty || inflight);
    raw_word  = fifo_empty ? mem2_q1_i : fifo_head;
    handshake = out_valid && m.m_ready_i;
    fifo_pop  = handshake && !fifo_empty;
    fifo_push = in_stream && inflight && !fifo_full && !(fifo_empty && handshake);
    occ_after = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, handshake};
    rd_issue  = in_stream && (rd_addr < DEPTH_C) && (occ_after < 3'd2);
  end

  always_comb begin
    mem2_ce1    = rd_issue;
    mem2_we1    = 1'b0;
    mem2_addr1  = rd_issue ? rd_addr[MEM2_ADDR_WIDTH-1:0] : '0;
    m.m_valid_o = out_valid;
    m.m_data_o  = out_valid ? out_word : '0;
    m.m_last_o  = out_valid && (out_idx == LAST_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr  <= '0;
      out_idx  <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_issue;
      if (state == S_IDLE && start_i) begin
        rd_addr <= '0;
        out_idx <= '0;
      end else begin
        if (rd_issue)  rd_addr <= rd_addr + 1'b1;
        if (handshake) out_idx <= out_idx + 1'b1;
      end
    end
  end

  fifo2_sync #(
    .WIDTH (MEM2_DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (mem2_q1_i),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef OFMAP_RELU_EN
  for (genvar l = 0; l < PE_SIZE; l++) begin : g_relu
    assign out_word[lane_lsb(l) +: DATA_WIDTH] =
      raw_word[lane_lsb(l) + DATA_WIDTH - 1] ? '0 : raw_word[lane_lsb(l) +: DATA_WIDTH];
  end
`else
  assign out_word = raw_word;
`endif

endmodule
